// File: rtl/color_frame_latch_pkg.sv
// -----------------------------------------------------------------------------
// color_frame_latch_pkg
//   Shared constants for the colour-switch conditioning stage in front of the
//   VGA top: default debounce length, colour bit positions and a helper that
//   sizes the debounce counter.
// -----------------------------------------------------------------------------
package color_frame_latch_pkg;

    // Default debounce length in clk cycles (10 ms at 100 MHz).
    localparam int DB_CYCLES_DEF = 1_000_000;

    // Number of colour switches and their positions on sw_in / rgb_out.
    localparam int N_BITS_DEF = 3;
    localparam int R_IDX      = 2;
    localparam int G_IDX      = 1;
    localparam int B_IDX      = 0;

    // Counter width for a debouncer that must count 0 .. cycles-1.
    // Guarded so a degenerate parameter still yields a legal 1-bit counter.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/color_frame_latch_debounce_bit.sv
// -----------------------------------------------------------------------------
// debounce_bit
//   One colour switch: 2-flop synchroniser followed by a counter debouncer.
//   The synchronised level must differ from the accepted level for DB_CYCLES
//   consecutive cycles before it is accepted; any return to the accepted
//   level restarts the count.
//
// Ports
//   clk   in  1  system clock
//   rst   in  1  asynchronous, active-low reset
//   sw    in  1  raw switch level, asynchronous to clk
//   db    out 1  debounced switch level
// -----------------------------------------------------------------------------
module debounce_bit
    import color_frame_latch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db
);

    localparam int            CW      = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // Synchroniser: sw is asynchronous, so only s2 is used downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    // Counter stops at CNT_MAX, where it is cleared as the new level is
    // accepted, so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (s2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            db  <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/color_frame_latch.sv
// -----------------------------------------------------------------------------
// color_frame_latch
//   Conditions the raw colour switches for the VGA top. Each switch bit is
//   synchronised and debounced, and the debounced colour is transferred to
//   rgb_out only at the start of vertical sync so that a colour change never
//   tears part-way through a frame.
//
// Ports
//   clk        in   1       system clock (same clock as the sync generator)
//   rst        in   1       asynchronous, active-low reset
//   sw_in      in   N_BITS  raw switches; bit2=R, bit1=G, bit0=B
//   v_sync     in   1       vertical sync from the sync generator
//   rgb_out    out  N_BITS  frame-stable colour to red/green/blue of VGA top
//   db_state   out  N_BITS  debounced switch state, before the frame latch
//   upd_pulse  out  1       1-cycle pulse when rgb_out changed at a frame edge
// -----------------------------------------------------------------------------
module color_frame_latch
    import color_frame_latch_pkg::*;
#(
    parameter int N_BITS     = N_BITS_DEF,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter bit VS_ACT_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] sw_in,
    input  logic              v_sync,
    output logic [N_BITS-1:0] rgb_out,
    output logic [N_BITS-1:0] db_state,
    output logic              upd_pulse
);

    logic vs_prev;
    logic fe;

    // One independent debouncer per colour switch.
    for (genvar i = 0; i < N_BITS; i++) begin : g_db
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk (clk),
            .rst (rst),
            .sw  (sw_in[i]),
            .db  (db_state[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= v_sync;
        end
    end

    // Frame edge = transition into the asserted v_sync level. Holding v_sync
    // asserted yields only this single cycle.
    always_comb begin
        fe = 1'b0;
        if (VS_ACT_LOW) begin
            fe = vs_prev & ~v_sync;
        end else begin
            fe = ~vs_prev & v_sync;
        end
    end

    // db_state is the registered debouncer output, so a debouncer update in
    // the fe cycle is not seen here until the following frame edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_out   <= '0;
            upd_pulse <= 1'b0;
        end else if (fe) begin
            rgb_out   <= db_state;
            upd_pulse <= (db_state != rgb_out);
        end else begin
            upd_pulse <= 1'b0;
        end
    end

endmodule
